// File: rtl/instrenc_if.sv
// Handshake and imem write-port bundle between the boot sequencer and the instruction encoder.
interface instrenc_if #(
  parameter int DEPTH_LOG2 = 6
);
  logic                  start;
  logic                  done;
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            kind;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [5:0]            funct;
  logic [15:0]           imm;
  logic [25:0]           target;
  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [31:0]           wdata;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  err;
  logic                  finished;

  modport master (
    output start, done, in_valid, kind, rs, rt, rd, funct, imm, target,
    input  in_ready, we, waddr, wdata, count, full, err, finished
  );

  modport slave (
    input  start, done, in_valid, kind, rs, rt, rd, funct, imm, target,
    output in_ready, we, waddr, wdata, count, full, err, finished
  );
endinterface

// File: rtl/instrenc.sv
// Packs field-level instruction descriptions into 32-bit MIPS words and streams them
// sequentially into instruction memory through a registered write port.
module instrenc #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  instrenc_if.slave   bus
);
  // state | meaning
  // IDLE  | after reset, waiting for the first start
  // LOAD  | session open, accepting instructions
  // DONE  | session closed, waiting for a new start
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DEPTH_LOG2:0] CNT_LAST = (DEPTH_LOG2+1)'((1 << DEPTH_LOG2) - 1);

  state_t                state_q;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] waddr_q;
  logic [31:0]           wdata_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  full_q;
  logic                  err_q;

  logic                  in_ready;
  logic                  accept;
  logic                  legal_d;
  logic [31:0]           wdata_d;

  assign in_ready = (state_q == S_LOAD) && !full_q;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    legal_d = 1'b1;
    wdata_d = 32'h0;
    case (bus.kind)
      3'd0: wdata_d = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, bus.funct};
      3'd1: wdata_d = {6'b100011, bus.rs, bus.rt, bus.imm};
      3'd2: wdata_d = {6'b101011, bus.rs, bus.rt, bus.imm};
      3'd3: wdata_d = {6'b000100, bus.rs, bus.rt, bus.imm};
      3'd4: wdata_d = {6'b001000, bus.rs, bus.rt, bus.imm};
      3'd5: wdata_d = {6'b000010, bus.target};
      default: legal_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q <= S_LOAD;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        S_LOAD: begin
          // The word count doubles as the next write address; it never wraps.
          if (accept) begin
            if (legal_d) begin
              we_q    <= 1'b1;
              waddr_q <= count_q[DEPTH_LOG2-1:0];
              wdata_q <= wdata_d;
              count_q <= count_q + 1'b1;
              full_q  <= (count_q == CNT_LAST);
            end else begin
              err_q <= 1'b1;
            end
          end
          if (bus.done) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.err      = err_q;
  assign bus.finished = (state_q == S_DONE);
endmodule

// File: doc/instrenc.md
# instrenc

Instruction encoder and instruction-memory loader: the encoding counterpart of the main decoder. Accepts field-level instruction descriptions (class, registers, immediate, jump target) over a valid/ready handshake and packs them into 32-bit MIPS words. Writes the words sequentially into a word-addressed instruction memory through a registered write port. Sits between the test/boot sequencer and the instruction memory, ahead of processor start.

## Interface
- DEPTH_LOG2, 6, log2 of instruction-memory depth in words (64 words)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a load session
- done  in  1  pulse; ends a load session
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept this cycle
- kind  in  3  0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6–7 illegal
- rs, rt, rd  in  5 each  register fields
- funct  in  6  R-type function code
- imm  in  16  immediate / branch offset
- target  in  26  jump target
- we  out  1  imem write strobe
- waddr  out  DEPTH_LOG2  imem word address
- wdata  out  32  encoded instruction
- count  out  DEPTH_LOG2+1  words written this session
- full  out  1  count == 2^DEPTH_LOG2
- err  out  1  sticky: illegal kind accepted this session
- finished  out  1  session closed

## Operation
- States: IDLE, LOAD, DONE. IDLE→LOAD on start; LOAD→DONE on done; DONE→LOAD on start (new session). done in IDLE ignored; start in LOAD ignored; start and done together in IDLE or DONE: start wins.
- Entering LOAD clears count, full, err, finished; next write goes to waddr 0.
- in_ready = (state == LOAD) && !full. Accept = in_valid && in_ready.
- Encodings, shamt always 0:
  - R: {000000, rs, rt, rd, 00000, funct}
  - lw: {100011, rs, rt, imm}
  - sw: {101011, rs, rt, imm}
  - beq: {000100, rs, rt, imm}
  - addi: {001000, rs, rt, imm}
  - j: {000010, target}
- Fields unused by a class are ignored.
- Illegal kind: handshake completes, no write, count unchanged, err set until next session start.
- Legal accept: count += 1; full asserts when count reaches 2^DEPTH_LOG2, deasserting in_ready. No wrap-around: addresses never return to 0 within a session.
- Accept and done in the same LOAD cycle: word is accepted and written; state goes to DONE.
- finished = (state == DONE).

## Timing
- Reset values: state IDLE, we 0, waddr 0, wdata 0, count 0, full 0, err 0, finished 0, in_ready 0.
- Reset asserted mid-session aborts immediately. No write strobe after deassertion until a new start/accept.
- in_ready is combinational from registered state and full only, with no dependence on in_valid.
- Latency: accept in cycle N → we=1 with waddr/wdata valid in cycle N+1 for exactly one cycle. count/full/err update at the end of cycle N.
- Throughput: one accept per cycle sustained, with back-to-back writes at consecutive addresses.
- The 64th accept in cycle N makes full=1 and in_ready=0 in cycle N+1. Its write still occurs in N+1.
- finished rises the cycle after done is sampled. A write from a same-cycle accept appears in that same cycle.

## Test plan
- Reset, start, one accept of kind 0, rs=1, rt=2, rd=3, funct=0x20 → next cycle we=1, waddr=0, wdata=0x00221820, then count=1.
- Back-to-back accepts of lw rt=2 imm=0x0050, sw rt=2 imm=0x0054, beq rs=1 rt=2 imm=3, addi rt=2 imm=5, j target=0x11 → wdata 0x8C020050, 0xAC020054, 0x10220003, 0x20020005, 0x08000011 at waddr 1–5 on consecutive cycles.
- Accept kind 6 between two legal words → no we for it, err=1, the next legal word lands at the next consecutive address, count excludes it. A new start clears err.
- Hold in_valid for 70 cycles → exactly 64 writes at waddr 0–63, full=1, in_ready=0 from the cycle after the 64th accept, no further we.
- Assert done together with an accept → that word is written, finished=1 next cycle, in_ready=0. Then start → count=0, next write at waddr 0.
- Assert reset (low) mid-stream with in_valid high → all outputs return to reset values asynchronously. After release, no we until start.
